pwm_multi: RTL and testbench

- Parametrised N-channel PWM peripheral on the uncore memory-mapped bus; successor to the two-channel PWM.
- Adds configurable counter width and channel count.
- Adds double-buffered (shadow) period/compare/deadtime registers that load at period boundaries.
- Adds true deadtime insertion in complementary mode, per-channel period-end status, and a maskable interrupt.

---
 rtl/pwm_multi_if.sv | 15 +
 rtl/pwm_multi.sv | 231 +++++++++++++++++++++++
 tb/tb_pwm_multi.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_multi_if.sv
// Memory-mapped register bus between the uncore and the PWM block.
// The master drives the address, data and strobes; the slave returns registered read data.
interface pwm_multi_if;
    logic [7:0]  address_i;
    logic [31:0] writedata_i;
    logic        write_i;
    logic        read_i;
    logic        chipselect_i;
    logic [31:0] readdata_o;

    modport master (output address_i, writedata_i, write_i, read_i, chipselect_i,
                    input  readdata_o);
    modport slave  (input  address_i, writedata_i, write_i, read_i, chipselect_i,
                    output readdata_o);
endinterface

// File: rtl/pwm_multi.sv
// N-channel PWM with a shared prescaler, shadowed period/compare/deadtime, complementary deadtime and maskable irq.
// Fault shutdown input (fault_i, STATUS bit 15) exists only when PWM_FAULT_EN is defined.
module pwm_multi #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    pwm_multi_if.slave        bus,
`ifdef PWM_FAULT_EN
    input  logic              fault_i,
`endif
    output logic [NUM_CH-1:0] pwm_h_o,
    output logic [NUM_CH-1:0] pwm_l_o,
    output logic              irq_o
);
    typedef logic [CNT_W-1:0] cnt_t;

    cnt_t              prescaler, psc_cnt;
    logic              gctrl_en, tick, fault_q, fault_blk;
    logic [NUM_CH-1:0] status, irqmask;
    logic [3:0]        cfg    [NUM_CH];
    cnt_t              per_sh [NUM_CH], cmp_sh [NUM_CH], dt_sh [NUM_CH];
    cnt_t              per_a  [NUM_CH], cmp_a  [NUM_CH], dt_a  [NUM_CH];
    cnt_t              cnt    [NUM_CH], cnt_n  [NUM_CH], dtc   [NUM_CH];
    logic [NUM_CH-1:0] run, down, down_n, raw_q, raw_n, active, step, bnd;
    logic [NUM_CH-1:0] h_c, l_c, inv;
    logic              wr, rd, ch_hit, wr_status;
    logic [7:0]        off;
    logic [2:0]        ch_sel;
    logic [1:0]        reg_sel;
    cnt_t              wdata;
    logic [31:0]       rd_val;
    logic              unused_wdata;

    assign wr        = bus.write_i & bus.chipselect_i;
    assign rd        = bus.read_i & bus.chipselect_i;
    assign off       = bus.address_i - 8'h10;
    assign ch_hit    = (bus.address_i >= 8'h10) && (off < 8'(4 * NUM_CH));
    assign ch_sel    = off[4:2];
    assign reg_sel   = off[1:0];
    assign wdata     = bus.writedata_i[CNT_W-1:0];
    assign wr_status = wr && (bus.address_i == 8'h02);
    assign unused_wdata = ^bus.writedata_i[31:CNT_W];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prescaler <= cnt_t'(49);
            gctrl_en  <= 1'b0;
            irqmask   <= '0;
            for (int n = 0; n < NUM_CH; n++) begin
                cfg[n]    <= '0;
                per_sh[n] <= cnt_t'(1023);
                cmp_sh[n] <= cnt_t'(512);
                dt_sh[n]  <= '0;
            end
        end else if (wr) begin
            case (bus.address_i)
                8'h00:   prescaler <= wdata;
                8'h01:   gctrl_en  <= bus.writedata_i[0];
                8'h03:   irqmask   <= bus.writedata_i[NUM_CH-1:0];
                default: ;
            endcase
            for (int n = 0; n < NUM_CH; n++) begin
                if (ch_hit && ch_sel == 3'(n)) begin
                    case (reg_sel)
                        2'd0: cfg[n]    <= bus.writedata_i[3:0];
                        2'd1: per_sh[n] <= wdata;
                        2'd2: cmp_sh[n] <= wdata;
                        2'd3: dt_sh[n]  <= wdata;
                    endcase
                end
            end
        end
    end

    // >= rather than == so a PRESCALER lowered below the running count recovers at once
    assign tick = gctrl_en && (psc_cnt >= prescaler);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                psc_cnt <= '0;
        else if (!gctrl_en || tick) psc_cnt <= '0;
        else                      psc_cnt <= psc_cnt + 1'b1;
    end

    always_comb begin
        bnd    = '0;
        raw_n  = '0;
        down_n = down;
        for (int n = 0; n < NUM_CH; n++) begin
            active[n] = gctrl_en & cfg[n][0];
            step[n]   = tick & active[n];
            cnt_n[n]  = cnt[n];
            if (!run[n]) begin
                // first tick after enabling starts the period at zero
                cnt_n[n]  = '0;
                down_n[n] = 1'b0;
            end else if (!cfg[n][1]) begin
                if (cnt[n] >= per_a[n]) begin
                    cnt_n[n] = '0;
                    bnd[n]   = step[n];
                end else begin
                    cnt_n[n] = cnt[n] + 1'b1;
                end
            end else if (per_a[n] == '0) begin
                cnt_n[n]  = '0;
                down_n[n] = 1'b0;
                bnd[n]    = step[n];
            end else if (!down[n]) begin
                if (cnt[n] >= per_a[n] - 1'b1) begin
                    cnt_n[n]  = per_a[n];
                    down_n[n] = 1'b1;
                end else begin
                    cnt_n[n] = cnt[n] + 1'b1;
                end
            end else if (cnt[n] <= cnt_t'(1)) begin
                cnt_n[n]  = '0;
                down_n[n] = 1'b0;
                bnd[n]    = step[n];
            end else begin
                cnt_n[n] = cnt[n] - 1'b1;
            end
            raw_n[n] = cnt_n[n] < (bnd[n] ? cmp_sh[n] : cmp_a[n]);
            h_c[n]   = cfg[n][2] ? (raw_q[n] & (dtc[n] == '0))  : raw_q[n];
            l_c[n]   = cfg[n][2] ? (~raw_q[n] & (dtc[n] == '0)) : raw_q[n];
            inv[n]   = cfg[n][3];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            run   <= '0;
            down  <= '0;
            raw_q <= '0;
            for (int n = 0; n < NUM_CH; n++) begin
                cnt[n]   <= '0;
                dtc[n]   <= '0;
                per_a[n] <= cnt_t'(1023);
                cmp_a[n] <= cnt_t'(512);
                dt_a[n]  <= '0;
            end
        end else begin
            for (int n = 0; n < NUM_CH; n++) begin
                if (!active[n]) begin
                    cnt[n]   <= '0;
                    dtc[n]   <= '0;
                    run[n]   <= 1'b0;
                    down[n]  <= 1'b0;
                    raw_q[n] <= 1'b0;
                    per_a[n] <= per_sh[n];
                    cmp_a[n] <= cmp_sh[n];
                    dt_a[n]  <= dt_sh[n];
                end else if (step[n]) begin
                    cnt[n]   <= cnt_n[n];
                    down[n]  <= down_n[n];
                    run[n]   <= 1'b1;
                    raw_q[n] <= raw_n[n];
                    if (raw_n[n] != raw_q[n]) dtc[n] <= bnd[n] ? dt_sh[n] : dt_a[n];
                    else if (dtc[n] != '0)    dtc[n] <= dtc[n] - 1'b1;
                    if (bnd[n]) begin
                        per_a[n] <= per_sh[n];
                        cmp_a[n] <= cmp_sh[n];
                        dt_a[n]  <= dt_sh[n];
                    end
                end
            end
        end
    end

`ifdef PWM_FAULT_EN
    logic [1:0] fsync;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fsync   <= '0;
            fault_q <= 1'b0;
        end else begin
            fsync <= {fsync[0], fault_i};
            if (fsync[1])                                  fault_q <= 1'b1;
            else if (wr_status && bus.writedata_i[15])     fault_q <= 1'b0;
        end
    end
    // synchronised level blocks outputs one cycle before the latch catches up
    assign fault_blk = fault_q | fsync[1];
`else
    assign fault_q   = 1'b0;
    assign fault_blk = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pwm_h_o <= '0;
            pwm_l_o <= '0;
            status  <= '0;
            irq_o   <= 1'b0;
        end else begin
            pwm_h_o <= active & run & {NUM_CH{~fault_blk}} & (h_c ^ inv);
            pwm_l_o <= active & run & {NUM_CH{~fault_blk}} & (l_c ^ inv);
            status  <= (wr_status ? (status & ~bus.writedata_i[NUM_CH-1:0]) : status) | bnd;
            irq_o   <= (|(status & irqmask)) | fault_q;
        end
    end

    always_comb begin
        rd_val = '0;
        case (bus.address_i)
            8'h00: rd_val = 32'(prescaler);
            8'h01: rd_val = {31'b0, gctrl_en};
            8'h02: begin
                rd_val     = 32'(status);
                rd_val[15] = fault_q;
            end
            8'h03: rd_val = 32'(irqmask);
            default: ;
        endcase
        for (int n = 0; n < NUM_CH; n++) begin
            if (ch_hit && ch_sel == 3'(n)) begin
                case (reg_sel)
                    2'd0: rd_val = 32'(cfg[n]);
                    2'd1: rd_val = 32'(per_sh[n]);
                    2'd2: rd_val = 32'(cmp_sh[n]);
                    2'd3: rd_val = 32'(dt_sh[n]);
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)   bus.readdata_o <= '0;
        else if (rd) bus.readdata_o <= rd_val;
    end
endmodule

// File: tb/tb_pwm_multi.sv
// Bench for pwm_multi: directed register/waveform checks plus randomized channel setups
// compared cycle by cycle against a closed-form position/waveform model.
module tb_pwm_multi;
    localparam int NUM_CH = 4;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [NUM_CH-1:0] pwm_h_o, pwm_l_o;
    logic              irq_o;
`ifdef PWM_FAULT_EN
    logic              fault_i;
`endif

    pwm_multi_if bus();

    pwm_multi #(.NUM_CH(NUM_CH), .CNT_W(16)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .bus     (bus),
`ifdef PWM_FAULT_EN
        .fault_i (fault_i),
`endif
        .pwm_h_o (pwm_h_o),
        .pwm_l_o (pwm_l_o),
        .irq_o   (irq_o)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk_i);
        bus.address_i = a; bus.writedata_i = d; bus.write_i = 1'b1; bus.chipselect_i = 1'b1;
        @(negedge clk_i);
        bus.write_i = 1'b0; bus.chipselect_i = 1'b0;
    endtask

    task automatic bus_rd(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk_i);
        bus.address_i = a; bus.read_i = 1'b1; bus.chipselect_i = 1'b1;
        @(negedge clk_i);
        bus.read_i = 1'b0; bus.chipselect_i = 1'b0;
        d = bus.readdata_o;
    endtask

    task automatic wait_rise(input int ch, output bit found);
        bit seen_low = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            @(negedge clk_i);
            if (!pwm_h_o[ch]) seen_low = 1'b1;
            else if (seen_low) found = 1'b1;
        end
    endtask

    // counts from the current sample onward
    task automatic count_win(input int ch, input int len, output int hc, output int lc, output int ov);
        hc = 0; lc = 0; ov = 0;
        for (int i = 0; i < len; i++) begin
            if (i > 0) @(negedge clk_i);
            hc += int'(pwm_h_o[ch]);
            lc += int'(pwm_l_o[ch]);
            ov += int'(pwm_h_o[ch] & pwm_l_o[ch]);
        end
    endtask

    // raw level at period position k (ticks since the channel started)
    function automatic bit raw_at(input int k, input int per, input int cmp, input bit ctr);
        int c;
        if (k < 0) return 1'b0;
        if (!ctr)          c = k % (per + 1);
        else if (per == 0) c = 0;
        else begin
            c = k % (2 * per);
            if (c > per) c = 2 * per - c;
        end
        return c < cmp;
    endfunction

    logic [31:0] rdat;
    int hc, lc, ov;
    bit found;
    int ch, psc, per, cmp, dt, first_b, jt, k;
    bit ctr, cm, inv, hi, lo;
    logic [NUM_CH-1:0] eh, el;

    initial begin
        rst_i = 1'b1;
        bus.address_i = '0; bus.writedata_i = '0;
        bus.write_i = 1'b0; bus.read_i = 1'b0; bus.chipselect_i = 1'b0;
`ifdef PWM_FAULT_EN
        fault_i = 1'b0;
`endif
        repeat (3) @(negedge clk_i);
        check("rst_h", 32'(pwm_h_o), 0);
        check("rst_l", 32'(pwm_l_o), 0);
        check("rst_irq", 32'(irq_o), 0);
        check("rst_rdata", bus.readdata_o, 0);
        rst_i = 1'b0;

        bus_rd(8'h00, rdat); check("rst_psc", rdat, 49);
        bus_rd(8'h11, rdat); check("rst_per1", rdat, 1023);
        bus_rd(8'h12, rdat); check("rst_cmp1", rdat, 512);
        bus_rd(8'h01, rdat); check("rst_gctrl", rdat, 0);
        bus_rd(8'h20, rdat); check("unmapped_ch4", rdat, 0);
        bus_wr(8'h21, 32'd77);
        bus_rd(8'h21, rdat); check("unmapped_wr", rdat, 0);
        bus_wr(8'h05, 32'd5);
        bus_rd(8'h05, rdat); check("unmapped_05", rdat, 0);

        // center mode, status and irq on ch1
        bus_wr(8'h00, 0);
        bus_wr(8'h15, 4); bus_wr(8'h16, 2);
        bus_wr(8'h03, 32'h2);
        bus_wr(8'h14, 32'h3);
        bus_wr(8'h01, 1);
        repeat (20) @(negedge clk_i);
        check("ctr_irq_set", 32'(irq_o), 1);
        count_win(1, 8, hc, lc, ov);
        check("ctr_h_cnt", 32'(hc), 3);
        check("ctr_l_eq_h", 32'(lc), 3);
        bus_rd(8'h02, rdat); check("ctr_status", rdat, 32'h2);
        bus_wr(8'h01, 0);
        bus_wr(8'h02, 32'h2);
        @(negedge clk_i);
        check("ctr_irq_clr", 32'(irq_o), 0);
        bus_rd(8'h02, rdat); check("ctr_status_clr", rdat, 0);
        bus_wr(8'h14, 0);

        // complementary mode with deadtime on ch0
        bus_wr(8'h11, 19); bus_wr(8'h12, 10); bus_wr(8'h13, 2);
        bus_wr(8'h10, 32'h5);
        bus_wr(8'h01, 1);
        repeat (25) @(negedge clk_i);
        count_win(0, 20, hc, lc, ov);
        check("cmp_h_cnt", 32'(hc), 8);
        check("cmp_l_cnt", 32'(lc), 8);
        check("cmp_overlap", 32'(ov), 0);
        bus_wr(8'h13, 12);
        repeat (45) @(negedge clk_i);
        count_win(0, 20, hc, lc, ov);
        check("cmp_dt12_h", 32'(hc), 0);
        check("cmp_dt12_ov", 32'(ov), 0);

        // mid-period compare change on ch0 edge mode
        bus_wr(8'h01, 0);
        bus_wr(8'h10, 32'h1); bus_wr(8'h11, 9); bus_wr(8'h12, 3); bus_wr(8'h13, 0);
        bus_wr(8'h01, 1);
        wait_rise(0, found); check("mid_rise0", 32'(found), 1);
        count_win(0, 10, hc, lc, ov);
        check("mid_old_h", 32'(hc), 3);
        check("mid_old_l", 32'(lc), 3);
        repeat (3) @(negedge clk_i);
        bus_wr(8'h12, 7);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            check("mid_hold_old", 32'(pwm_h_o[0]), 0);
        end
        bus_rd(8'h12, rdat); check("mid_readback", rdat, 7);
        wait_rise(0, found); check("mid_rise1", 32'(found), 1);
        count_win(0, 10, hc, lc, ov);
        check("mid_new_h", 32'(hc), 7);
        bus_wr(8'h01, 0);
        bus_wr(8'h10, 0);
        bus_wr(8'h02, 32'hFFFF);

        // randomized single-channel runs against the closed-form model
        for (int it = 0; it < 24; it++) begin
            ch  = $urandom_range(NUM_CH - 1, 0);
            psc = $urandom_range(2, 0);
            per = $urandom_range(12, 0);
            cmp = $urandom_range(per + 2, 0);
            dt  = $urandom_range(5, 0);
            ctr = 1'($urandom_range(1, 0));
            cm  = 1'($urandom_range(1, 0));
            inv = 1'($urandom_range(1, 0));
            first_b = ctr ? ((per == 0) ? 1 : 2 * per) : per + 1;
            bus_wr(8'h00, psc);
            bus_wr(8'(8'h11 + 4 * ch), per);
            bus_wr(8'(8'h12 + 4 * ch), cmp);
            bus_wr(8'(8'h13 + 4 * ch), dt);
            bus_wr(8'h03, 32'(1) << ch);
            bus_wr(8'(8'h10 + 4 * ch), {28'b0, inv, cm, ctr, 1'b1});
            bus_wr(8'h01, 1);
            for (int n = 1; n <= 60; n++) begin
                @(negedge clk_i);
                jt = (n - 1) / (psc + 1);
                eh = '0; el = '0;
                if (jt > 0) begin
                    k = jt - 1;
                    if (cm) begin
                        hi = 1'b1; lo = 1'b1;
                        for (int m = k - dt; m <= k; m++) begin
                            if (raw_at(m, per, cmp, ctr)) lo = 1'b0;
                            else                          hi = 1'b0;
                        end
                    end else begin
                        hi = raw_at(k, per, cmp, ctr);
                        lo = hi;
                    end
                    eh[ch] = hi ^ inv;
                    el[ch] = lo ^ inv;
                end
                check("rnd_h", 32'(pwm_h_o), 32'(eh));
                check("rnd_l", 32'(pwm_l_o), 32'(el));
                check("rnd_irq", 32'(irq_o), 32'(jt - 1 >= first_b));
            end
            bus_wr(8'h01, 0);
            bus_wr(8'(8'h10 + 4 * ch), 0);
            bus_wr(8'h02, 32'hFFFF);
        end

`ifdef PWM_FAULT_EN
        bus_wr(8'h00, 0);
        bus_wr(8'h11, 9); bus_wr(8'h12, 15);
        bus_wr(8'h10, 32'h1);
        bus_wr(8'h01, 1);
        repeat (5) @(negedge clk_i);
        check("flt_pre_h", 32'(pwm_h_o[0]), 1);
        fault_i = 1'b1;
        repeat (3) @(negedge clk_i);
        check("flt_h_off", 32'(pwm_h_o), 0);
        check("flt_l_off", 32'(pwm_l_o), 0);
        bus_rd(8'h02, rdat); check("flt_status", 32'(rdat[15]), 1);
        check("flt_irq", 32'(irq_o), 1);
        bus_wr(8'h02, 32'h8000);
        bus_rd(8'h02, rdat); check("flt_hold", 32'(rdat[15]), 1);
        fault_i = 1'b0;
        repeat (4) @(negedge clk_i);
        bus_wr(8'h02, 32'h8000);
        repeat (3) @(negedge clk_i);
        check("flt_resume", 32'(pwm_h_o[0]), 1);
        bus_rd(8'h02, rdat); check("flt_cleared", 32'(rdat[15]), 0);
`else
        bus_rd(8'h02, rdat); check("nofault_bit15", 32'(rdat[15]), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
